// File: rtl/lc3b_types.sv
// Shared LC-3b type package: bus word type, memory-stage state encoding and
// the byte-enable helpers used by the memory-access stage.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lc3b_mem_state;

    localparam logic [1:0] LC3B_BE_WORD = 2'b11;

    // A control word with no lanes selected is treated as a full-word access.
    function automatic logic [1:0] norm_byte_en(input logic [1:0] be);
        return (be == 2'b00) ? LC3B_BE_WORD : be;
    endfunction

endpackage

// File: rtl/lc3b_mem_stage_if.sv
// Single-ported data-memory request/response bus between the MEM stage
// (master) and the data memory (slave).
interface lc3b_mem_stage_if;
    import lc3b_types::*;

    lc3b_word   mem_address;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_byte_enable;
    lc3b_word   mem_wdata;
    lc3b_word   mem_rdata;
    logic       mem_resp;

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering: word-aligns addresses, replicates store bytes
// across both lanes and right-justifies byte loads.
module mem_lane_align
    import lc3b_types::*;
(
    input  logic [1:0] byte_en,
    input  lc3b_word   addr,
    input  lc3b_word   wdata,
    input  lc3b_word   rdata,
    output lc3b_word   mem_addr,
    output lc3b_word   mem_wdata,
    output logic [1:0] lane_be,
    output lc3b_word   load_data
);

    // Derive address, store data, lane enables and load data from byte_en.
    always_comb begin
        lane_be   = norm_byte_en(byte_en);
        mem_addr  = addr;
        mem_wdata = wdata;
        load_data = rdata;
        if (lane_be == LC3B_BE_WORD) begin
            mem_addr = {addr[15:1], 1'b0};
        end else begin
            mem_wdata = {wdata[7:0], wdata[7:0]};
        end
        case (lane_be)
            2'b01:   load_data = {8'h00, rdata[7:0]};
            2'b10:   load_data = {8'h00, rdata[15:8]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/lc3b_mem_stage.sv
// LC-3b MEM stage: accepts an EX/MEM instruction, runs at most one data-memory
// access with a timeout, and holds the aligned result for writeback.
module lc3b_mem_stage
    import lc3b_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_mem_read,
    input  logic       in_mem_write,
    input  logic [1:0] in_byte_en,
    input  lc3b_word   in_addr,
    input  lc3b_word   in_wdata,
    lc3b_mem_stage_if.master mem,
    output logic       out_valid,
    input  logic       out_ready,
    output lc3b_word   out_data,
    output logic       out_err
);

    localparam lc3b_word TIMEOUT_W = lc3b_word'(TIMEOUT_CYCLES);

    lc3b_mem_state state_q, state_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [1:0]    be_q, be_d;
    lc3b_word      addr_q, addr_d;
    lc3b_word      wdata_q, wdata_d;
    lc3b_word      wait_cnt_q, wait_cnt_d;
    lc3b_word      out_data_q, out_data_d;
    logic          out_err_q, out_err_d;
    lc3b_word      wait_inc;

    lc3b_word      align_addr;
    lc3b_word      align_wdata;
    logic [1:0]    lane_be;
    lc3b_word      load_data;

    mem_lane_align u_align (
        .byte_en   (be_q),
        .addr      (addr_q),
        .wdata     (wdata_q),
        .rdata     (mem.mem_rdata),
        .mem_addr  (align_addr),
        .mem_wdata (align_wdata),
        .lane_be   (lane_be),
        .load_data (load_data)
    );

    // Requests are decoded from state so reset removes them immediately.
    // An illegal read+write performs only the write.
    assign mem.mem_read        = (state_q == REQ) && rd_q && !wr_q;
    assign mem.mem_write       = (state_q == REQ) && wr_q;
    assign mem.mem_address     = align_addr;
    assign mem.mem_wdata       = align_wdata;
    assign mem.mem_byte_enable = wr_q ? lane_be : LC3B_BE_WORD;

    assign out_valid = (state_q == RESP);
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

    // Next-state, capture and result logic; acceptance overrides the state arm.
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wait_cnt_d = wait_cnt_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        wait_inc   = wait_cnt_q + 16'd1;
        in_ready   = (state_q == IDLE) || ((state_q == RESP) && out_ready);

        unique case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            REQ: begin
                // A response in the timeout cycle still completes normally.
                if (mem.mem_resp) begin
                    state_d    = RESP;
                    // Stores return their effective address as the result.
                    out_data_d = wr_q ? addr_q : load_data;
                    out_err_d  = rd_q && wr_q;
                end else if (wait_inc == TIMEOUT_W) begin
                    state_d    = RESP;
                    out_data_d = '0;
                    out_err_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            RESP: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (in_ready && in_valid) begin
            rd_d    = in_mem_read;
            wr_d    = in_mem_write;
            be_d    = in_byte_en;
            addr_d  = in_addr;
            wdata_d = in_wdata;
            if (in_mem_read || in_mem_write) begin
                state_d    = REQ;
                wait_cnt_d = '0;
            end else begin
                state_d    = RESP;
                out_data_d = in_addr;
                out_err_d  = 1'b0;
            end
        end
    end

    // State, captured control word, wait counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            be_q       <= LC3B_BE_WORD;
            addr_q     <= '0;
            wdata_q    <= '0;
            wait_cnt_q <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wait_cnt_q <= wait_cnt_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

endmodule

// File: doc/lc3b_mem_stage.md
# lc3b_mem_stage

Memory-access stage controller for the pipelined LC-3b datapath. It consumes the memory fields of the decoded control word (`mem_read`, `mem_write`, `mem_byte_enable`), carried down the pipeline from decode, together with the EX-stage address and store data. It drives the single-ported data-memory request/response interface and holds the instruction until `mem_resp` returns. It then presents the aligned result to the writeback latch with a valid/ready handshake, and exposes backpressure (`in_ready`) to the pipeline.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles in REQ before the access is aborted (1..65535).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: EX/MEM latch holds an instruction.
- `in_ready` output 1: stage accepts the instruction this cycle.
- `in_mem_read` input 1: control-word mem_read.
- `in_mem_write` input 1: control-word mem_write.
- `in_byte_en` input 2: control-word mem_byte_enable (01 low byte, 10 high byte, 11 word).
- `in_addr` input 16: effective address (ALU result).
- `in_wdata` input 16: store data (SR value).
- `mem_address` output 16: data-memory address.
- `mem_read` output 1: read request.
- `mem_write` output 1: write request.
- `mem_byte_enable` output 2: write lane enables.
- `mem_wdata` output 16: write data.
- `mem_rdata` input 16: read data, valid with `mem_resp`.
- `mem_resp` input 1: access complete, one-cycle pulse.
- `out_valid` output 1: result held for writeback.
- `out_ready` input 1: writeback consumes the result.
- `out_data` output 16: aligned load data, or `in_addr` passthrough for non-memory ops.
- `out_err` output 1: qualifies `out_valid`; access timed out or had an illegal control combination.

## Operation
- States are IDLE, REQ and RESP.
- **IDLE:** `in_ready`=1. When `in_valid` is high, register the inputs.
  - If the op is a memory op, go to REQ.
  - Otherwise go to RESP with `out_data`=`in_addr`.
- **REQ:** `mem_read`/`mem_write` are driven from registered fields. All `mem_*` outputs stay stable until `mem_resp`.
  - On `mem_resp`, capture the aligned data and go to RESP.
  - `in_ready`=0 in REQ.
- **RESP:** `out_valid`=1. `in_ready` equals `out_ready`.
  - If `out_ready` and `in_valid` are both high, accept the next instruction. Go to REQ or RESP by the same rule as IDLE.
  - If `out_ready` is high and `in_valid` is low, go to IDLE.
  - If `out_ready` is low, hold all outputs.
- **Illegal control (`in_mem_read` and `in_mem_write` both high):** perform the write only, and set `out_err` on the result.
- **Address alignment:**
  - Word access (`byte_en`=11): `mem_address` = {addr[15:1],0}.
  - Byte access: `mem_address` = addr unchanged.
- **Reads:** `mem_byte_enable`=11.
- **Load data:**
  - 11 gives `mem_rdata`.
  - 01 gives {8'h00, rdata[7:0]}.
  - 10 gives {8'h00, rdata[15:8]}.
- **Write data:**
  - Word access gives `wdata`.
  - Byte access gives {wdata[7:0], wdata[7:0]}, with `mem_byte_enable` = `in_byte_en`.
  - `byte_en`=00 is treated as 11.
- **Wait counter:** 16-bit, cleared on entry to REQ and incremented each REQ cycle without `mem_resp`.
  - When the count reaches `TIMEOUT_CYCLES`, deassert requests, go to RESP with `out_data`=0 and `out_err`=1.
  - A `mem_resp` arriving in the same cycle as the timeout wins: normal completion.
- A `mem_resp` seen outside REQ is ignored.

## Timing
- **Reset values:** state IDLE; `in_ready`=1; `mem_read`=`mem_write`=0; `mem_address`=`mem_wdata`=0; `mem_byte_enable`=11; `out_valid`=0; `out_data`=0; `out_err`=0.
- `mem_read` and `mem_write` are decoded from state, so they drop immediately on `rst_n` assertion.
- **Reset mid-REQ:** abandon the access with no completion. A later stray `mem_resp` is ignored.
- **Non-memory op:** accept in cycle N, `out_valid` in N+1.
- **Memory op:** accept in N, request visible in N+1. With `mem_resp` in cycle N+k (k≥1), `out_valid` rises in N+k+1.
- Minimum memory latency is 2 cycles from accept to `out_valid`.
- Throughput is 1 non-memory op per cycle when `out_ready` is held high.
- `out_data` and `out_err` are registered and stable while `out_valid` is high and `out_ready` is low.

## Structure
- Add to the shared `lc3b_types` package:
  - enum `lc3b_mem_state` {IDLE, REQ, RESP};
  - constant `LC3B_BE_WORD`=2'b11.
- Reuse `lc3b_word` for all 16-bit buses.
- One combinational sub-module, `mem_lane_align`, takes byte_en, addr, wdata and rdata and produces the aligned address, write data, lane enables and load data.
- The FSM, input registers and wait counter live in `lc3b_mem_stage`.

## Test plan
- **Non-memory op:** ADD with addr=16'h1234 and `out_ready`=1 → `out_valid` next cycle, `out_data`=16'h1234, no `mem_read` or `mem_write` ever asserted.
- **Word load:** addr=16'h3001, byte_en=11, `mem_resp` after 3 cycles with rdata=16'hBEEF → `mem_address`=16'h3000 held stable for 3 cycles; `out_data`=16'hBEEF.
- **Byte store:** addr=16'h2005, byte_en=10, wdata=16'h00A5 → `mem_wdata`=16'hA5A5, `mem_byte_enable`=10, `mem_write` held until `mem_resp`.
- **Backpressure:** `out_ready`=0 for 4 cycles in RESP → `in_ready`=0 and `out_data` stable. When `out_ready` and `in_valid` rise together, the next op is accepted the same cycle.
- **Timeout:** TIMEOUT_CYCLES=8 and no `mem_resp` → requests drop after 8 cycles; `out_err`=1, `out_data`=0. A `mem_resp` arriving exactly at cycle 8 → normal completion instead.
- **Reset mid-REQ:** `rst_n` low while `mem_read` is high → `mem_read` drops immediately; after release, `in_ready`=1 and a late `mem_resp` produces no `out_valid`.
